// File: rtl/mux_demux_pkg.sv
// Shared constants and types for the mux_demux loopback block.
// Used by both mux_demux and mux_demux_route.
package mux_demux_pkg;

    localparam int N_DEFAULT = 4;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

    localparam int SEL_W_DEFAULT = $clog2(N_DEFAULT);

    typedef logic [SEL_W_DEFAULT-1:0] sel_t;

endpackage

// File: rtl/mux_demux_route.sv
// Demux stage: routes the registered link bit onto the lane named by the aligned select.
// MUX_DEMUX_HOLD_EN keeps non-selected lanes (deserialiser); otherwise they are cleared each enabled cycle.
module mux_demux_route
    import mux_demux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             link_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [N-1:0]     demux_o
);

    logic [N-1:0] demux_q;
    logic [N-1:0] demux_d;

    always_comb begin
`ifdef MUX_DEMUX_HOLD_EN
        demux_d = demux_q;
`else
        demux_d = '0;
`endif
        demux_d[sel_i] = link_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            demux_q <= '0;
        end else if (en) begin
            demux_q <= demux_d;
        end
    end

    assign demux_o = demux_q;

endmodule

// File: rtl/mux_demux.sv
// Registered N:1 mux onto a one-bit link, looped back through a 1:N demux on a delayed select.
// Optional MUX_DEMUX_HOLD_EN turns the demux into a deserialiser that keeps non-selected lanes.
module mux_demux
    import mux_demux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     data_in,
    input  logic [SEL_W-1:0] select_lines,
    output logic             mux_out,
    output logic [N-1:0]     demux_out,
    output logic [SEL_W-1:0] sel_q
);

    logic             mux_q;
    logic             mux_d;
    logic [SEL_W-1:0] sel_reg_q;
    logic [SEL_W-1:0] sel_reg_d;

    always_comb begin
        mux_d     = data_in[select_lines];
        sel_reg_d = select_lines;
    end

    // sel_reg_q travels with mux_q so the demux routes each bit to the lane it came from
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_q     <= 1'b0;
            sel_reg_q <= '0;
        end else if (en) begin
            mux_q     <= mux_d;
            sel_reg_q <= sel_reg_d;
        end
    end

    mux_demux_route #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_route (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .link_i  (mux_q),
        .sel_i   (sel_reg_q),
        .demux_o (demux_out)
    );

    assign mux_out = mux_q;
    assign sel_q   = sel_reg_q;

endmodule

// File: tb/tb_mux_demux.sv
// Self-checking bench for mux_demux (N=4): directed test-plan scenarios plus random traffic
// compared against a history-based reference model. Honours MUX_DEMUX_HOLD_EN.
module tb_mux_demux;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] data_in;
    logic [1:0] select_lines;
    logic       mux_out;
    logic [3:0] demux_out;
    logic [1:0] sel_q;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       b;
        logic [1:0] s;
    } smp_t;

    // every enabled sample since the last reset, oldest first
    smp_t hist[$];

    mux_demux dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .data_in      (data_in),
        .select_lines (select_lines),
        .mux_out      (mux_out),
        .demux_out    (demux_out),
        .sel_q        (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_mux();
        if (hist.size() == 0) return 1'b0;
        return hist[hist.size()-1].b;
    endfunction

    function automatic logic [1:0] exp_sel();
        if (hist.size() == 0) return 2'd0;
        return hist[hist.size()-1].s;
    endfunction

    function automatic logic [3:0] exp_demux();
        logic [3:0] r;
        int n;
        r = 4'b0000;
        n = hist.size();
`ifdef MUX_DEMUX_HOLD_EN
        // each lane shows the newest bit that has reached the demux for that lane
        for (int i = 0; i < n - 1; i++) r[hist[i].s] = hist[i].b;
`else
        if (n >= 2) r[hist[n-2].s] = hist[n-2].b;
`endif
        return r;
    endfunction

    task automatic step(input logic e, input logic r, input logic [3:0] d, input logic [1:0] s);
        en           = e;
        rst          = r;
        data_in      = d;
        select_lines = s;
        @(posedge clk);
        if (r) hist.delete();
        else if (e) hist.push_back('{d[s], s});
        #1;
        check("mux_out",   32'(mux_out),   32'(exp_mux()));
        check("sel_q",     32'(sel_q),     32'(exp_sel()));
        check("demux_out", 32'(demux_out), 32'(exp_demux()));
    endtask

    logic [3:0] sweep_mux [4];
    logic [3:0] sweep_dmx [4];
    logic [3:0] frozen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sweep_mux[0] = 4'd0; sweep_mux[1] = 4'd1; sweep_mux[2] = 4'd0; sweep_mux[3] = 4'd1;
`ifdef MUX_DEMUX_HOLD_EN
        sweep_dmx[0] = 4'b0000; sweep_dmx[1] = 4'b0010; sweep_dmx[2] = 4'b0010; sweep_dmx[3] = 4'b1010;
`else
        sweep_dmx[0] = 4'b0000; sweep_dmx[1] = 4'b0010; sweep_dmx[2] = 4'b0000; sweep_dmx[3] = 4'b1000;
`endif

        // reset state
        step(1'b0, 1'b1, 4'b0000, 2'd0);
        check("rst_mux",   32'(mux_out),   32'd0);
        check("rst_demux", 32'(demux_out), 32'd0);

        // select sweep
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'b1010, 2'(k));
            check("sweep_mux", 32'(mux_out), 32'(sweep_mux[k]));
            if (k >= 1) check("sweep_demux", 32'(demux_out), 32'(sweep_dmx[k-1]));
        end
        step(1'b1, 1'b0, 4'b1010, 2'd3);
        check("sweep_demux", 32'(demux_out), 32'(sweep_dmx[3]));

        // reset mid-stream, then two enabled edges before data reaches demux_out
        step(1'b1, 1'b1, 4'b1111, 2'd2);
        check("midrst_demux", 32'(demux_out), 32'd0);
        step(1'b1, 1'b0, 4'b1111, 2'd2);
        check("postrst_e1_demux", 32'(demux_out), 32'd0);
        step(1'b1, 1'b0, 4'b1111, 2'd2);
        check("postrst_e2_demux", 32'(demux_out), 32'b0100);

        // enable stall
        step(1'b1, 1'b1, 4'b0000, 2'd0);
        step(1'b1, 1'b0, 4'b1111, 2'd2);
        frozen = demux_out;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 4'b0000, 2'd1);
            check("stall_mux",   32'(mux_out),   32'd1);
            check("stall_sel",   32'(sel_q),     32'd2);
            check("stall_demux", 32'(demux_out), 32'(frozen));
        end
        step(1'b1, 1'b0, 4'b1111, 2'd2);
        check("stall_resume_demux", 32'(demux_out), 32'b0100);

        // reset with en low
        step(1'b0, 1'b1, 4'b1111, 2'd3);
        check("rst_en0_mux",   32'(mux_out),   32'd0);
        check("rst_en0_sel",   32'(sel_q),     32'd0);
        check("rst_en0_demux", 32'(demux_out), 32'd0);

        // data follows select
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, (k % 2 == 0) ? 4'b0000 : 4'b1000, 2'd3);
            check("follow_mux", 32'(mux_out), 32'(k % 2));
        end

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 4'($urandom), 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_demux.md
# mux_demux

Registered N:1 multiplexer feeding a 1:N demultiplexer that share one select bus. One input bit, chosen by the select, is serialised onto a single-bit link. The same select, delayed to stay aligned, routes that bit back to the matching output lane. The block serves as a loopback and self-check path for narrow select-routed links.

## Interface
Parameters:
- `N`, default 4: number of data lanes; power of two, minimum 2.
- `SEL_W`, default `$clog2(N)`: select width; derived, never overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: stage advance; when low, all registers hold.
- `data_in`, input, N: parallel lanes presented to the multiplexer.
- `select_lines`, input, SEL_W: lane index, shared by mux and demux.
- `mux_out`, output, 1: registered serial link bit, equal to `data_in[select_lines]`.
- `demux_out`, output, N: registered demultiplexed lanes.
- `sel_q`, output, SEL_W: select value aligned with `mux_out`.

## Operation
- Mux stage, on `en`: `mux_out <= data_in[select_lines]` and `sel_q <= select_lines`.
- Demux stage, on `en`: lane `sel_q` of `demux_out` receives `mux_out`.
- Non-selected lanes of `demux_out` are 0 (default build; see Configuration).
- Both stages advance together; there is no handshake.
- `select_lines` values are always in range because N is a power of two. No out-of-range case exists.
- `en` low: `mux_out`, `sel_q` and `demux_out` all hold their values.
- `rst` high: `mux_out`, `sel_q` and `demux_out` go to 0 on the next edge. Reset overrides `en`.

## Timing
- Mux latency is 1 cycle: inputs sampled at edge k appear on `mux_out` and `sel_q` after edge k.
- Demux latency is 1 further cycle: `demux_out` reflects the inputs sampled at edge k after edge k+1.
- Throughput is one select per enabled cycle.
- Back-to-back select changes are pipelined with no bubbles.
- Reset mid-stream flushes both stages.
  - The first valid `demux_out` after reset release appears 2 enabled edges later.
  - Until then, `demux_out` reads 0.
- Inputs need only meet setup and hold to `clk`. No combinational path runs from inputs to outputs.

## Configuration
- Macro `MUX_DEMUX_HOLD_EN`.
- Defined:
  - Non-selected `demux_out` lanes keep their previous value, so the block acts as a deserialiser.
  - Sweeping every select value reconstructs `data_in` on `demux_out`.
  - Reset still clears all lanes.
- Undefined: non-selected lanes are forced to 0 every enabled cycle (one-hot routing).

## Structure
- Package `mux_demux_pkg`:
  - default `N` constant;
  - `sel_w(n)` function returning `$clog2(n)`;
  - typedef for the select vector at the default width.
- Sub-module `mux_demux_route`: the demux stage, holding the `demux_out` register and the hold/zero logic.
- The top level contains the mux stage and `sel_q`, and instantiates `mux_demux_route`.

## Test plan
All scenarios use N=4.
- **Select sweep.** `data_in`=1010, select 00, 01, 10, 11 on successive cycles, `en`=1.
  - `mux_out` sequence: 0, 1, 0, 1, one cycle late.
  - `demux_out` sequence: 0000, 0010, 0000, 1000, two cycles late (default build).
- **Hold build.** Same stimulus with `MUX_DEMUX_HOLD_EN` defined.
  - `demux_out` steps 0000 → 0010 → 0010 → 1010.
- **Enable stall.** `data_in`=1111, select 10, `en` dropped for 3 cycles after the first edge.
  - `mux_out`=1 and `sel_q`=10 hold.
  - `demux_out` stays frozen, then becomes 0100 one enabled edge after `en` returns.
- **Reset mid-stream.** Assert `rst` while `demux_out`=1000.
  - After the next edge, all outputs are 0.
  - After release, 2 enabled edges are needed before nonzero output.
  - Reset asserted with `en`=0 still clears all outputs.
- **Data follows select.** Select fixed at 11, `data_in` toggled 0000 ↔ 1000 each cycle.
  - `mux_out` alternates 0/1.
  - `demux_out` alternates 0000/1000 with 2-cycle latency.
